// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle,
// signed operands handled as magnitudes with a sign fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Read_data1,
  input  logic [WIDTH-1:0] Read_data2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            sgn, an, bn;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  shifted;
  logic [WIDTH:0]  diff;
  logic [PW-1:0]   prod_fix;
  logic [WIDTH-1:0] quo, rem;

  // prod_q holds {acc, multiplier} for multiply and {rem, quotient} for divide
  assign sum      = {1'b0, prod_q[PW-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, a_q} : '0);
  assign shifted  = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign quo      = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem      = rneg_q ? -prod_q[PW-1:WIDTH] : prod_q[PW-1:WIDTH];

  assign sgn = ~op[0];
  assign an  = sgn & Read_data1[WIDTH-1];
  assign bn  = sgn & Read_data2[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = op[1];
          neg_d   = an ^ bn;
          rneg_d  = an;
          a_d     = an ? -Read_data1 : Read_data1;
          b_d     = bn ? -Read_data2 : Read_data2;
          prod_d  = {{WIDTH{1'b0}}, op[1] ? a_d : b_d};
        end else begin
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      CALC: begin
        if (div_q) begin
          if (!diff[WIDTH]) begin
            prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
          end else begin
            prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          prod_d = {sum, prod_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = (b_q == '0) ? '1 : quo;
          hi_d = rem;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle model plus directed
// vectors with hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rd1, rd2;
  logic        mthi, mtlo;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .Read_data1 (rd1),
    .Read_data2 (rd2),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Architectural result: {HI, LO}
  function automatic logic [63:0] ref_res(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = '0;
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = ua * ub;
      default: begin
        if (b == 32'h0) begin
          r = {a, 32'hFFFFFFFF};
        end else if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end else begin
          r = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    return r;
  endfunction

  int          m_cnt = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  // Result lands 33 edges after acceptance
  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = 33;
        m_busy = 1'b1;
        m_res  = ref_res(op, rd1, rd2);
      end else begin
        if (mthi) m_hi = wr_data;
        if (mtlo) m_lo = wr_data;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        {m_hi, m_lo} = m_res;
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'h0, busy}, {31'h0, m_busy});
      chk("done", {31'h0, done}, {31'h0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    op    = o;
    rd1   = a;
    rd2   = b;
  endtask

  task automatic wait_done(input string name, input logic [31:0] eh,
                           input logic [31:0] el, input int inj);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (inj != 0 && i == inj) begin
        issue(2'b10, 32'd9, 32'd3);
        mthi    = 1'b1;
        wr_data = 32'h12345678;
      end
      if (inj != 0 && i == inj + 1) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      chk({name, " latency"}, 32'(lat), 32'd34);
      chk({name, " hi"}, hi, eh);
      chk({name, " lo"}, lo, el);
    end
  endtask

  initial begin
    int seen;
    rst_n   = 1'b0;
    start   = 1'b1;
    op      = 2'b01;
    rd1     = 32'h5;
    rd2     = 32'h6;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu max", 32'hFFFFFFFE, 32'h00000001, 0);
    @(negedge clk);
    chk("done one cycle", {31'h0, done}, 32'h0);

    issue(2'b00, 32'hFFFFFFF9, 32'd3);
    wait_done("mult -7x3", 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    issue(2'b00, 32'h80000000, 32'h80000000);
    wait_done("mult min^2", 32'h40000000, 32'h00000000, 0);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    issue(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done("div 7/-2", 32'h00000001, 32'hFFFFFFFD, 0);
    issue(2'b11, 32'd100, 32'd0);
    wait_done("divu by 0", 32'h00000064, 32'hFFFFFFFF, 0);
    issue(2'b10, 32'hFFFFFFF9, 32'd0);
    wait_done("div by 0 neg", 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div ovf", 32'h00000000, 32'h80000000, 0);
    issue(2'b11, 32'd100, 32'd7);
    wait_done("divu 100/7", 32'd2, 32'd14, 0);

    issue(2'b01, 32'd5, 32'd6);
    wait_done("busy block", 32'h0, 32'h1E, 10);
    @(negedge clk);
    mtlo    = 1'b1;
    wr_data = 32'hCAFEBABE;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo", lo, 32'hCAFEBABE);
    mthi    = 1'b1;
    mtlo    = 1'b1;
    wr_data = 32'h000055AA;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthi+mtlo hi", hi, 32'h000055AA);
    chk("mthi+mtlo lo", lo, 32'h000055AA);

    issue(2'b11, 32'd1000, 32'd3);
    mthi    = 1'b1;
    wr_data = 32'h0BADF00D;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        mthi  = 1'b0;
        chk("start beats mthi", hi, 32'h000055AA);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'h0, busy}, 32'h0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no done after abort", 32'(seen), 32'd0);

    issue(2'b01, 32'd3, 32'd4);
    wait_done("b2b first", 32'h0, 32'd12, 0);
    issue(2'b11, 32'd100, 32'd7);
    wait_done("b2b second", 32'd2, 32'd14, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
